// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: MD op codes, FSM states, result record.
// Latency: none (declarations only).
// Backpressure: not applicable; the unit itself exports busy, and stall control acts on it.
package md_pkg;

    // MD operation codes carried in the ID/EX register. MFHI/MFLO are not here:
    // Execute reads hi/lo directly.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    // Counter width: $clog2 of the longer latency, never below one bit.
    function automatic int md_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath producing the {hi,lo} result and a divide-by-zero flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; md_unit samples the result on the accepting edge.
// Ports: i_op/i_rs_val/i_rt_val in; o_res ({hi,lo}) and o_div_zero out.
module md_compute
    import md_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    output md_res_t     o_res,
    output logic        o_div_zero
);

    logic        w_div_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    // Low 64 bits of a product of sign-extended operands equals the signed product.
    assign w_prod_s = {{32{i_rs_val[31]}}, i_rs_val} * {{32{i_rt_val[31]}}, i_rt_val};
    assign w_prod_u = {32'd0, i_rs_val} * {32'd0, i_rt_val};

    // Signed divide runs on magnitudes, then re-applies signs. The magnitude of
    // 0x80000000 is 0x80000000 unsigned, so MIN/-1 naturally yields 0x80000000 rem 0.
    assign w_div_signed = (i_op == MD_DIV);
    assign w_a_mag  = (w_div_signed && i_rs_val[31]) ? (32'd0 - i_rs_val) : i_rs_val;
    assign w_b_mag  = (w_div_signed && i_rt_val[31]) ? (32'd0 - i_rt_val) : i_rt_val;
    // Keeps the divider well defined on rt=0; the result is discarded in that case.
    assign w_b_safe = (i_rt_val == 32'd0) ? 32'd1 : w_b_mag;
    assign w_quo    = w_a_mag / w_b_safe;
    assign w_rem    = w_a_mag % w_b_safe;

    always_comb begin
        o_res      = '0;
        o_div_zero = 1'b0;
        case (i_op)
            MD_MULT:  o_res = w_prod_s;
            MD_MULTU: o_res = w_prod_u;
            MD_DIV, MD_DIVU: begin
                o_div_zero = (i_rt_val == 32'd0);
                o_res.lo   = (w_div_signed && (i_rs_val[31] ^ i_rt_val[31])) ? (32'd0 - w_quo) : w_quo;
                o_res.hi   = (w_div_signed && i_rs_val[31]) ? (32'd0 - w_rem) : w_rem;
            end
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU latency model with architectural HI/LO and MTHI/MTLO writes.
// Latency: MULT* busy MULT_CYCLES, DIV* busy DIV_CYCLES; MTHI/MTLO visible the next cycle.
// Backpressure: starts while busy are dropped; stall control must hold D while busy or start.
// Ports: clk, reset (sync, active-high), start/op/rs_val/rt_val in; busy, hi, lo out (all registered).
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = md_cnt_w(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    md_res_t          r_pend;
    logic             r_pend_dz;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    md_res_t          w_res;
    logic             w_div_zero;

    md_compute u_compute (
        .i_op       (op),
        .i_rs_val   (rs_val),
        .i_rt_val   (rt_val),
        .o_res      (w_res),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_pend_dz <= 1'b0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                r_state   <= ST_RUN;
                                r_busy    <= 1'b1;
                                r_cnt     <= MULT_LOAD;
                                r_pend    <= w_res;
                                r_pend_dz <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_state   <= ST_RUN;
                                r_busy    <= 1'b1;
                                r_cnt     <= DIV_LOAD;
                                r_pend    <= w_res;
                                r_pend_dz <= w_div_zero;
                            end
                            MD_MTHI: r_hi <= rs_val;
                            MD_MTLO: r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        // Divide by zero burns the full latency but leaves HI/LO intact.
                        if (!r_pend_dz) begin
                            r_hi <= r_pend.hi;
                            r_lo <= r_pend.lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
